// File: rtl/clk_div_pkg.sv
// Shared types and constants for the run-time clock divider controller.
package clk_div_pkg;
  localparam int DEF_CNT_W = 8;
  localparam int MIN_DIV   = 2;

  typedef enum logic [2:0] {
    ST_STOP       = 3'd0,
    ST_RUN        = 3'd1,
    ST_PEND       = 3'd2,
    ST_DRAIN      = 3'd3,
    ST_DRAIN_PEND = 3'd4
  } state_e;
endpackage

// File: rtl/clk_div_counter_core.sv
// Wrap counter plus registered divided-clock phase; both forced low while stopped or cleared.
module clk_div_counter_core #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             run,
  input  logic             clear,
  input  logic [CNT_W-1:0] div,
  output logic [CNT_W-1:0] count,
  output logic             count_end,
  output logic             div_clk
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             div_clk_q, div_clk_d;

  always_comb begin
    count_end = run && (count_q == (div - ONE));
    count_d   = count_q;
    div_clk_d = 1'b0;
    if (clear || !run) begin
      count_d = '0;
    end else begin
      count_d   = count_end ? '0 : count_q + ONE;
      // Odd ratios give the high phase the extra cycle.
      div_clk_d = (count_q >= (div >> 1));
    end
  end

  always_ff @(posedge clk) begin
    count_q   <= count_d;
    div_clk_q <= div_clk_d;
  end

  assign count   = count_q;
  assign div_clk = div_clk_q;
endmodule

// File: rtl/clk_div_ctrl.sv
// Start/stop and ratio-change sequencer; every change lands on a counter wrap.
// Handshake: a ratio transfers on any edge where i_div_valid && o_div_ready; ready depends only on state.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int DEF_DIV = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  input  logic             i_div_valid,
  input  logic [CNT_W-1:0] i_div,
  output logic             o_div_ready,
  output logic             o_div_clk,
  output logic [CNT_W-1:0] o_count,
  output logic             o_count_end,
  output logic             o_busy,
  output logic             o_err,
  output state_e           o_dbg_state
);
  localparam logic [CNT_W-1:0] DEF_DIV_V = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] MIN_DIV_V = CNT_W'(MIN_DIV);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cur_div_q, cur_div_d;
  logic [CNT_W-1:0] pend_div_q, pend_div_d;
  logic             err_q, err_d;
  logic             count_end;
  logic             xfer, legal;

  assign o_div_ready = (state_q == ST_STOP) || (state_q == ST_RUN);
  assign xfer        = i_div_valid && o_div_ready;
  assign legal       = (i_div >= MIN_DIV_V);

  always_comb begin
    state_d    = state_q;
    cur_div_d  = cur_div_q;
    pend_div_d = pend_div_q;
    err_d      = xfer && !legal;
    unique case (state_q)
      ST_STOP: begin
        if (xfer && legal) cur_div_d = i_div;
        if (i_en) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (xfer && legal) begin
          pend_div_d = i_div;
          state_d    = i_en ? ST_PEND : ST_DRAIN_PEND;
        end else if (!i_en) begin
          state_d = ST_DRAIN;
        end
      end
      ST_PEND: begin
        if (count_end) begin
          cur_div_d = pend_div_q;
          state_d   = i_en ? ST_RUN : ST_DRAIN;
        end else if (!i_en) begin
          state_d = ST_DRAIN_PEND;
        end
      end
      ST_DRAIN: begin
        // An enable seen at or before the wrap cancels the stop.
        if (count_end) state_d = i_en ? ST_RUN : ST_STOP;
        else if (i_en) state_d = ST_RUN;
      end
      ST_DRAIN_PEND: begin
        if (count_end) begin
          cur_div_d = pend_div_q;
          state_d   = i_en ? ST_RUN : ST_STOP;
        end else if (i_en) begin
          state_d = ST_PEND;
        end
      end
      default: state_d = ST_STOP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_STOP;
      cur_div_q  <= DEF_DIV_V;
      pend_div_q <= DEF_DIV_V;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_div_q  <= cur_div_d;
      pend_div_q <= pend_div_d;
      err_q      <= err_d;
    end
  end

  clk_div_counter_core #(.CNT_W(CNT_W)) u_core (
    .clk       (clk),
    .run       (state_q != ST_STOP),
    .clear     (reset),
    .div       (cur_div_q),
    .count     (o_count),
    .count_end (count_end),
    .div_clk   (o_div_clk)
  );

  assign o_count_end = count_end;
  assign o_busy      = (state_q != ST_STOP);
  assign o_err       = err_q;
  assign o_dbg_state = state_q;
endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: hand vectors, directed corner sequences and a randomized run vs. a reference model.
module tb_clk_div_ctrl;
  import clk_div_pkg::*;

  logic       clk = 1'b0;
  logic       reset, i_en, i_div_valid;
  logic [7:0] i_div;
  logic       o_div_ready, o_div_clk, o_count_end, o_busy, o_err;
  logic [7:0] o_count;
  state_e     dbg_state;

  clk_div_ctrl #(.CNT_W(8), .DEF_DIV(8)) dut (
    .clk(clk), .reset(reset), .i_en(i_en), .i_div_valid(i_div_valid), .i_div(i_div),
    .o_div_ready(o_div_ready), .o_div_clk(o_div_clk), .o_count(o_count),
    .o_count_end(o_count_end), .o_busy(o_busy), .o_err(o_err), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference model: a running flag, a stop-requested flag and an optional pending ratio.
  bit m_active, m_drain, m_has_pend, m_clk, m_err;
  int m_cnt, m_cur, m_pend;

  function automatic bit m_ready();
    return !m_active || (!m_drain && !m_has_pend);
  endfunction

  task automatic model_step();
    bit wrap, xfer, legal, n_clk;
    int n_cnt;
    if (reset) begin
      m_active = 0; m_drain = 0; m_has_pend = 0; m_clk = 0; m_err = 0;
      m_cnt = 0; m_cur = 8; m_pend = 8;
    end else begin
      wrap  = m_active && (m_cnt == m_cur - 1);
      xfer  = i_div_valid && m_ready();
      legal = (i_div >= 2);
      n_clk = m_active && (m_cnt >= m_cur / 2);
      n_cnt = (!m_active || wrap) ? 0 : m_cnt + 1;
      m_err = xfer && !legal;
      if (!m_active) begin
        if (xfer && legal) m_cur = i_div;
        m_active = i_en; m_drain = 0; m_has_pend = 0;
      end else begin
        if (wrap && m_drain && !i_en) m_active = 0;
        if (wrap && m_has_pend) begin m_cur = m_pend; m_has_pend = 0; end
        if (xfer && legal) begin m_pend = i_div; m_has_pend = 1; end
        m_drain = m_active ? !i_en : 1'b0;
      end
      m_clk = n_clk;
      m_cnt = n_cnt;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("m_count", o_count, m_cnt);
    check("m_div_clk", o_div_clk, m_clk);
    check("m_busy", o_busy, m_active);
    check("m_ready", o_div_ready, m_ready());
    check("m_count_end", o_count_end, m_active && (m_cnt == m_cur - 1));
    check("m_err", o_err, m_err);
  endtask

  task automatic do_reset();
    reset = 1; i_div_valid = 0; tick(); reset = 0;
  endtask

  task automatic wait_count(input int v);
    int n = 0;
    while (o_count != v && n < 600) begin tick(); n++; end
    check("wait_count", o_count, v);
  endtask

  task automatic wait_end(output int n);
    n = 0;
    while (!o_count_end && n < 600) begin tick(); n++; end
    check("wait_end_timeout", o_count_end, 1);
  endtask

  task automatic measure_period(output int n);
    tick(); n = 1;
    while (!o_count_end && n < 600) begin tick(); n++; end
    check("period_timeout", o_count_end, 1);
  endtask

  typedef struct {
    logic rst, en, val; logic [7:0] div;
    int cnt; logic dclk, busy, rdy, cend, err;
  } vec_t;
  vec_t tbl[24];

  initial begin
    int n;
    reset = 1; i_en = 0; i_div_valid = 0; i_div = 0;
    //          rst en val div  cnt clk busy rdy end err
    tbl[0]  = '{1, 0, 0, 0,    0, 0, 0, 1, 0, 0};
    tbl[1]  = '{0, 1, 0, 0,    0, 0, 1, 1, 0, 0};
    tbl[2]  = '{0, 1, 0, 0,    1, 0, 1, 1, 0, 0};
    tbl[3]  = '{0, 1, 0, 0,    2, 0, 1, 1, 0, 0};
    tbl[4]  = '{0, 1, 0, 0,    3, 0, 1, 1, 0, 0};
    tbl[5]  = '{0, 1, 0, 0,    4, 0, 1, 1, 0, 0};
    tbl[6]  = '{0, 1, 0, 0,    5, 1, 1, 1, 0, 0};
    tbl[7]  = '{0, 1, 0, 0,    6, 1, 1, 1, 0, 0};
    tbl[8]  = '{0, 1, 0, 0,    7, 1, 1, 1, 1, 0};
    tbl[9]  = '{0, 1, 0, 0,    0, 1, 1, 1, 0, 0};
    tbl[10] = '{0, 1, 0, 0,    1, 0, 1, 1, 0, 0};
    tbl[11] = '{1, 0, 0, 0,    0, 0, 0, 1, 0, 0};
    tbl[12] = '{0, 0, 1, 5,    0, 0, 0, 1, 0, 0};
    tbl[13] = '{0, 1, 0, 0,    0, 0, 1, 1, 0, 0};
    tbl[14] = '{0, 1, 0, 0,    1, 0, 1, 1, 0, 0};
    tbl[15] = '{0, 1, 0, 0,    2, 0, 1, 1, 0, 0};
    tbl[16] = '{0, 1, 0, 0,    3, 1, 1, 1, 0, 0};
    tbl[17] = '{0, 1, 0, 0,    4, 1, 1, 1, 1, 0};
    tbl[18] = '{0, 1, 0, 0,    0, 1, 1, 1, 0, 0};
    tbl[19] = '{0, 1, 0, 0,    1, 0, 1, 1, 0, 0};
    tbl[20] = '{0, 1, 1, 1,    2, 0, 1, 1, 0, 1};
    tbl[21] = '{0, 1, 0, 0,    3, 1, 1, 1, 0, 0};
    tbl[22] = '{0, 1, 0, 0,    4, 1, 1, 1, 1, 0};
    tbl[23] = '{0, 1, 0, 0,    0, 1, 1, 1, 0, 0};

    for (int i = 0; i < 24; i++) begin
      reset = tbl[i].rst; i_en = tbl[i].en; i_div_valid = tbl[i].val; i_div = tbl[i].div;
      tick();
      check($sformatf("tbl%0d_count", i), o_count, tbl[i].cnt);
      check($sformatf("tbl%0d_div_clk", i), o_div_clk, tbl[i].dclk);
      check($sformatf("tbl%0d_busy", i), o_busy, tbl[i].busy);
      check($sformatf("tbl%0d_ready", i), o_div_ready, tbl[i].rdy);
      check($sformatf("tbl%0d_count_end", i), o_count_end, tbl[i].cend);
      check($sformatf("tbl%0d_err", i), o_err, tbl[i].err);
    end
    reset = 0; i_div_valid = 0;

    // Ratio change 8 -> 4 mid-period.
    do_reset(); i_en = 1;
    wait_count(2);
    i_div_valid = 1; i_div = 4; tick(); i_div_valid = 0;
    check("s2_ready_low", o_div_ready, 0);
    exp_q.push_back(4); exp_q.push_back(4); exp_q.push_back(4);
    wait_end(n);
    check("s2_old_wrap", n, exp_q.pop_front());
    measure_period(n); check("s2_period_a", n, exp_q.pop_front());
    measure_period(n); check("s2_period_b", n, exp_q.pop_front());

    // Stop request drains the current period.
    do_reset(); i_en = 1;
    wait_count(1);
    i_en = 0; n = 0;
    while (o_busy && n < 50) begin tick(); n++; end
    check("s3_stop_cycles", n, 7);
    check("s3_stop_count", o_count, 0);
    tick();
    check("s3_stop_div_clk", o_div_clk, 0);
    check("s3_stop_busy", o_busy, 0);

    // Re-enable during drain: no interruption.
    do_reset(); i_en = 1;
    wait_count(1);
    i_en = 0;
    wait_count(5);
    i_en = 1;
    wait_end(n); check("s3v_to_wrap", n, 2);
    measure_period(n); check("s3v_period", n, 8);
    check("s3v_busy", o_busy, 1);

    // Transfer on the exact wrap cycle.
    do_reset(); i_en = 1;
    wait_end(n); check("s5_first_period", n, 8);
    i_div_valid = 1; i_div = 3; tick(); i_div_valid = 0;
    check("s5_wrap_count", o_count, 0);
    wait_end(n); check("s5_full_old_period", n, 7);
    measure_period(n); check("s5_new_period", n, 3);

    // Reset during a pending change discards it.
    do_reset(); i_en = 1;
    wait_count(2);
    i_div_valid = 1; i_div = 4; tick(); i_div_valid = 0;
    wait_count(6);
    check("s6_in_pend", dbg_state, ST_PEND);
    reset = 1; tick(); reset = 0;
    check("s6_count", o_count, 0);
    check("s6_div_clk", o_div_clk, 0);
    check("s6_busy", o_busy, 0);
    check("s6_state", dbg_state, ST_STOP);
    wait_end(n); check("s6_first_period", n, 8);
    measure_period(n); check("s6_period", n, 8);

    // Randomized traffic against the model.
    do_reset(); i_en = 1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 15) == 0) i_en = ~i_en;
      i_div_valid = ($urandom_range(0, 3) == 0);
      i_div = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 12));
      reset = ($urandom_range(0, 599) == 0);
      tick();
    end
    reset = 0; i_div_valid = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
